// File: rtl/mem_xfer_ctrl.sv
// Arbitrates NUM_CH word requestors onto single-line DMA read/write channels, doing
// word extract on reads and line read-modify-write on writes. Optional macro: MEM_XFER_LINE_CACHE_EN.
//
// state     | meaning
// IDLE      | waiting for a request; grants round-robin
// RD_GO     | line read start pulse
// RD_WAIT   | waiting for read data
// RD_POP    | pop line into line register
// MERGE     | splice write word into line register
// WR_GO     | line write start pulse
// WR_WAIT_F | waiting for room in write path
// WR_PUSH   | push merged line
// WR_WAIT_D | waiting for line write completion
// DONE      | completion pulse to granted channel
module mem_xfer_ctrl #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 64,
  parameter int WORD_W = 32,
  parameter int CL_W   = 512
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               host_init,
  input  logic [NUM_CH-1:0]                  ch_req,
  input  logic [2*NUM_CH-1:0]                ch_op,
  input  logic [ADDR_W*NUM_CH-1:0]           ch_addr,
  input  logic [WORD_W*NUM_CH-1:0]           ch_wdata,
  output logic [NUM_CH-1:0]                  ch_done,
  output logic [NUM_CH-1:0]                  ch_err,
  output logic [WORD_W-1:0]                  ch_rdata,
  output logic                               ready,
  output logic                               dma_rd_go,
  output logic [ADDR_W-1:0]                  dma_rd_addr,
  output logic [ADDR_W-$clog2(CL_W/8):0]     dma_rd_size,
  input  logic                               dma_rd_empty,
  input  logic [CL_W-1:0]                    dma_rd_data,
  output logic                               dma_rd_en,
  output logic                               dma_wr_go,
  output logic [ADDR_W-1:0]                  dma_wr_addr,
  output logic [ADDR_W-$clog2(CL_W/8):0]     dma_wr_size,
  input  logic                               dma_wr_full,
  output logic [CL_W-1:0]                    dma_wr_data,
  output logic                               dma_wr_en,
  input  logic                               dma_wr_done
);

  localparam int WPL    = CL_W / WORD_W;
  localparam int OFF_LO = $clog2(WORD_W / 8);
  localparam int OFF_HI = $clog2(CL_W / 8);
  localparam int SZ_W   = ADDR_W - OFF_HI + 1;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WI_W   = (WPL > 1) ? $clog2(WPL) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(CL_W / 8) - ADDR_W'(1));
  localparam logic [1:0] OP_RD = 2'b01;
  localparam logic [1:0] OP_WR = 2'b10;

  typedef enum logic [3:0] {
    IDLE, RD_GO, RD_WAIT, RD_POP, MERGE, WR_GO, WR_WAIT_F, WR_PUSH, WR_WAIT_D, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     rr_q, idx_q, arb_idx, cand;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   addr_q, line_addr;
  logic [WORD_W-1:0]   wdata_q, word_sel;
  logic [CL_W-1:0]     line_q, merged;
  logic [WI_W-1:0]     word_idx;
  logic [NUM_CH-1:0]   ch_err_q;
  logic                wr_done_seen_q;
  logic                arb_hit, grant, illegal, hit;
  logic                rd_go, rd_en, wr_go, wr_en, done_pulse;

  logic [1:0]          op_arr    [NUM_CH];
  logic [ADDR_W-1:0]   addr_arr  [NUM_CH];
  logic [WORD_W-1:0]   wdata_arr [NUM_CH];
  logic [1:0]          sel_op;
  logic [ADDR_W-1:0]   sel_addr;
  logic [WORD_W-1:0]   sel_wdata;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign op_arr[g]    = ch_op[2*g +: 2];
    assign addr_arr[g]  = ch_addr[ADDR_W*g +: ADDR_W];
    assign wdata_arr[g] = ch_wdata[WORD_W*g +: WORD_W];
  end

  // first requester at or after the round-robin pointer
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = rr_q;
    cand    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = CH_W'((int'(rr_q) + k) % NUM_CH);
      if (!arb_hit && ch_req[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  assign sel_op    = op_arr[arb_idx];
  assign sel_addr  = addr_arr[arb_idx];
  assign sel_wdata = wdata_arr[arb_idx];
  assign illegal   = (sel_op != OP_RD) && (sel_op != OP_WR);
  // the cycle an error pulses, the offending requester has not yet dropped its request
  assign grant     = (state_q == IDLE) && host_init && arb_hit && (ch_err_q == '0);

  assign line_addr = addr_q & LINE_MASK;
  assign word_idx  = WI_W'((addr_q >> OFF_LO) & ADDR_W'(WPL - 1));

`ifdef MEM_XFER_LINE_CACHE_EN
  logic              valid_q;
  logic [ADDR_W-1:0] tag_q;

  assign hit = valid_q && (tag_q == (sel_addr & LINE_MASK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
    end else if (state_q == RD_POP || state_q == WR_PUSH) begin
      valid_q <= 1'b1;
      tag_q   <= line_addr;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    rd_go      = 1'b0;
    rd_en      = 1'b0;
    wr_go      = 1'b0;
    wr_en      = 1'b0;
    done_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant && !illegal) begin
          if (hit && sel_op == OP_RD) state_d = DONE;
          else if (hit)               state_d = MERGE;
          else                        state_d = RD_GO;
        end
      end
      RD_GO: begin
        rd_go   = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT:   if (!dma_rd_empty) state_d = RD_POP;
      RD_POP: begin
        rd_en   = 1'b1;
        state_d = (op_q == OP_WR) ? MERGE : DONE;
      end
      MERGE:     state_d = WR_GO;
      WR_GO: begin
        wr_go   = 1'b1;
        state_d = WR_WAIT_F;
      end
      WR_WAIT_F: if (!dma_wr_full) state_d = WR_PUSH;
      WR_PUSH: begin
        wr_en   = 1'b1;
        state_d = WR_WAIT_D;
      end
      WR_WAIT_D: if (dma_wr_done || wr_done_seen_q) state_d = DONE;
      DONE: begin
        done_pulse = 1'b1;
        state_d    = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= '0;
      idx_q    <= '0;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ch_err_q <= '0;
    end else begin
      ch_err_q <= '0;
      if (grant) begin
        idx_q   <= arb_idx;
        op_q    <= sel_op;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        rr_q    <= (arb_idx == CH_W'(NUM_CH - 1)) ? '0 : arb_idx + CH_W'(1);
        if (illegal) ch_err_q <= NUM_CH'(1) << arb_idx;
      end
    end
  end

  // done level only counts once WR_GO has retired the previous transfer's level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_done_seen_q <= 1'b0;
    end else if (state_q == WR_GO) begin
      wr_done_seen_q <= 1'b0;
    end else if ((state_q == WR_WAIT_F || state_q == WR_PUSH) && dma_wr_done) begin
      wr_done_seen_q <= 1'b1;
    end
  end

  always_comb begin
    merged   = line_q;
    word_sel = '0;
    for (int w = 0; w < WPL; w++) begin
      if (WI_W'(w) == word_idx) begin
        merged[w*WORD_W +: WORD_W] = wdata_q;
        word_sel                   = line_q[w*WORD_W +: WORD_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 line_q <= '0;
    else if (state_q == RD_POP) line_q <= dma_rd_data;
    else if (state_q == MERGE)  line_q <= merged;
  end

  assign ch_done     = done_pulse ? (NUM_CH'(1) << idx_q) : '0;
  assign ch_err      = ch_err_q;
  assign ch_rdata    = (done_pulse && op_q == OP_RD) ? word_sel : '0;
  assign ready       = (state_q == IDLE) && host_init;
  assign dma_rd_go   = rd_go;
  assign dma_rd_en   = rd_en;
  assign dma_rd_addr = line_addr;
  assign dma_rd_size = SZ_W'(1);
  assign dma_wr_go   = wr_go;
  assign dma_wr_en   = wr_en;
  assign dma_wr_addr = line_addr;
  assign dma_wr_size = SZ_W'(1);
  assign dma_wr_data = line_q;

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Directed bench for mem_xfer_ctrl: reads, RMW write, arbitration, illegal ops, gating, reset.
module tb_mem_xfer_ctrl;
  localparam int NUM_CH = 2;
  localparam int ADDR_W = 64;
  localparam int WORD_W = 32;
  localparam int CL_W   = 512;
  localparam int SZ_W   = 59;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       host_init = 1'b0;
  logic [NUM_CH-1:0]          ch_req = '0;
  logic [2*NUM_CH-1:0]        ch_op = '0;
  logic [ADDR_W*NUM_CH-1:0]   ch_addr = '0;
  logic [WORD_W*NUM_CH-1:0]   ch_wdata = '0;
  logic [NUM_CH-1:0]          ch_done, ch_err;
  logic [WORD_W-1:0]          ch_rdata;
  logic                       ready;
  logic                       dma_rd_go, dma_rd_en, dma_wr_go, dma_wr_en;
  logic [ADDR_W-1:0]          dma_rd_addr, dma_wr_addr;
  logic [SZ_W-1:0]            dma_rd_size, dma_wr_size;
  logic                       dma_rd_empty = 1'b0;
  logic [CL_W-1:0]            dma_rd_data = '0;
  logic                       dma_wr_full = 1'b0;
  logic [CL_W-1:0]            dma_wr_data;
  logic                       dma_wr_done = 1'b1;

  int checks = 0;
  int errors = 0;
  int n_rd_go = 0, n_rd_en = 0, n_wr_go = 0, n_wr_en = 0;
  logic [ADDR_W-1:0] last_rd_addr = '0, last_wr_addr = '0;
  logic [CL_W-1:0]   last_wr_data = '0;
  int full_cnt = 0, done_cnt = 0;

  mem_xfer_ctrl #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .WORD_W(WORD_W), .CL_W(CL_W)) dut (
    .clk(clk), .rst_n(rst_n), .host_init(host_init),
    .ch_req(ch_req), .ch_op(ch_op), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_done(ch_done), .ch_err(ch_err), .ch_rdata(ch_rdata), .ready(ready),
    .dma_rd_go(dma_rd_go), .dma_rd_addr(dma_rd_addr), .dma_rd_size(dma_rd_size),
    .dma_rd_empty(dma_rd_empty), .dma_rd_data(dma_rd_data), .dma_rd_en(dma_rd_en),
    .dma_wr_go(dma_wr_go), .dma_wr_addr(dma_wr_addr), .dma_wr_size(dma_wr_size),
    .dma_wr_full(dma_wr_full), .dma_wr_data(dma_wr_data), .dma_wr_en(dma_wr_en),
    .dma_wr_done(dma_wr_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dma_rd_go) begin n_rd_go++; last_rd_addr = dma_rd_addr; end
    if (dma_rd_en) n_rd_en++;
    if (dma_wr_go) begin n_wr_go++; last_wr_addr = dma_wr_addr; end
    if (dma_wr_en) begin n_wr_en++; last_wr_data = dma_wr_data; end
  end

  // write-side DMA: done drops on go, full for 2 cycles, done 2 cycles after push
  always @(negedge clk) begin
    if (!rst_n) begin
      full_cnt    = 0;
      done_cnt    = 0;
      dma_wr_full = 1'b0;
    end else begin
      if (full_cnt > 0) begin
        full_cnt--;
        if (full_cnt == 0) dma_wr_full = 1'b0;
      end
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) dma_wr_done = 1'b1;
      end
      if (dma_wr_go) begin
        dma_wr_done = 1'b0;
        dma_wr_full = 1'b1;
        full_cnt    = 2;
      end
      if (dma_wr_en) done_cnt = 2;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [CL_W-1:0] obs, input logic [CL_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input int ch, input logic [1:0] op, input logic [63:0] addr,
                      input logic [31:0] wd, output int lat, output logic [1:0] dn,
                      output logic [1:0] er, output logic [31:0] rd);
    @(negedge clk);
    ch_req   = 2'(1) << ch;
    ch_op    = 4'(op) << (2 * ch);
    ch_addr  = 128'(addr) << (64 * ch);
    ch_wdata = 64'(wd) << (32 * ch);
    lat = 0;
    dn  = '0;
    er  = '0;
    rd  = '0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (ch_done != '0 || ch_err != '0) begin
        dn = ch_done;
        er = ch_err;
        rd = ch_rdata;
        break;
      end
    end
    ch_req = '0;
  endtask

  function automatic logic [CL_W-1:0] ramp();
    logic [CL_W-1:0] r = '0;
    for (int i = 15; i >= 0; i--) r = {r[CL_W-33:0], 32'(i)};
    return r;
  endfunction

  initial begin
    int lat, b_rd, b_rdn, b_wr, b_wrn, got, cyc;
    logic [1:0] dn, er, dseen;
    logic [31:0] rd;
    logic [1:0] seq [4];
    logic [31:0] rds [4];

    // reset values
    #12;
    check("rst_ready",   CL_W'(ready), CL_W'(0));
    check("rst_done",    CL_W'(ch_done), CL_W'(0));
    check("rst_rd_go",   CL_W'(dma_rd_go), CL_W'(0));
    check("rst_rd_size", CL_W'(dma_rd_size), CL_W'(1));
    check("rst_wr_size", CL_W'(dma_wr_size), CL_W'(1));
    check("rst_wr_data", dma_wr_data, CL_W'(0));
    @(negedge clk);
    rst_n     = 1'b1;
    host_init = 1'b1;
    @(negedge clk);
    check("ready_idle", CL_W'(ready), CL_W'(1));

    // read ch0 0x1000_0044 -> line 0x...40, word 1
    dma_rd_data = ramp();
    b_rd = n_rd_go; b_rdn = n_rd_en; b_wr = n_wr_go;
    xfer(0, 2'b01, 64'h1000_0044, 32'h0, lat, dn, er, rd);
    check("rd_latency", CL_W'(lat), CL_W'(4));
    check("rd_done",    CL_W'(dn), CL_W'(2'b01));
    check("rd_data",    CL_W'(rd), CL_W'(32'h1));
    check("rd_addr",    CL_W'(last_rd_addr), CL_W'(64'h1000_0040));
    check("rd_go_cnt",  CL_W'(n_rd_go - b_rd), CL_W'(1));
    check("rd_en_cnt",  CL_W'(n_rd_en - b_rdn), CL_W'(1));
    check("rd_no_wr",   CL_W'(n_wr_go - b_wr), CL_W'(0));

    // write RMW ch1 0x2000_007C (word 15), stale done level high beforehand
    dma_rd_data = {16{32'hA5A5_A5A5}};
    b_rd = n_rd_go; b_wr = n_wr_go; b_wrn = n_wr_en;
    xfer(1, 2'b10, 64'h2000_007C, 32'hDEAD_BEEF, lat, dn, er, rd);
    check("wr_done",    CL_W'(dn), CL_W'(2'b10));
    check("wr_latency", CL_W'(lat), CL_W'(11));
    check("wr_addr",    CL_W'(last_wr_addr), CL_W'(64'h2000_0040));
    check("wr_data",    last_wr_data, {32'hDEAD_BEEF, {15{32'hA5A5_A5A5}}});
    check("wr_rd_go",   CL_W'(n_rd_go - b_rd), CL_W'(1));
    check("wr_go_cnt",  CL_W'(n_wr_go - b_wr), CL_W'(1));
    check("wr_en_cnt",  CL_W'(n_wr_en - b_wrn), CL_W'(1));

    // arbitration: both channels request continuously
    dma_rd_data = ramp();
    @(negedge clk);
    ch_op   = 4'b0101;
    ch_addr = {64'h3000_003C, 64'h3000_0008};
    ch_req  = 2'b11;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ch_done != '0) begin
        seq[got] = ch_done;
        rds[got] = ch_rdata;
        got++;
      end
    end
    ch_req = '0;
    check("arb_count", CL_W'(got), CL_W'(4));
    for (int i = 0; i < 4; i++) begin
      check("arb_grant", CL_W'(seq[i]), (i % 2 == 0) ? CL_W'(2'b01) : CL_W'(2'b10));
      check("arb_rdata", CL_W'(rds[i]), (i % 2 == 0) ? CL_W'(2) : CL_W'(15));
    end

    // illegal ops
    b_rd = n_rd_go; b_wr = n_wr_go;
    xfer(0, 2'b11, 64'h1000_0000, 32'h0, lat, dn, er, rd);
    check("ill11_err",  CL_W'(er), CL_W'(2'b01));
    check("ill11_lat",  CL_W'(lat), CL_W'(1));
    check("ill11_done", CL_W'(dn), CL_W'(0));
    xfer(1, 2'b00, 64'h1000_0000, 32'h0, lat, dn, er, rd);
    check("ill00_err",  CL_W'(er), CL_W'(2'b10));
    check("ill_no_dma", CL_W'((n_rd_go - b_rd) + (n_wr_go - b_wr)), CL_W'(0));

    // host_init low blocks grants
    b_rd = n_rd_go;
    @(negedge clk);
    host_init = 1'b0;
    ch_op  = 4'b0101;
    ch_req = 2'b11;
    dseen  = '0;
    repeat (8) begin
      @(negedge clk);
      dseen = dseen | ch_done;
    end
    check("gate_ready", CL_W'(ready), CL_W'(0));
    check("gate_done",  CL_W'(dseen), CL_W'(0));
    check("gate_rd_go", CL_W'(n_rd_go - b_rd), CL_W'(0));
    ch_req = '0;
    @(negedge clk);
    host_init = 1'b1;
    @(negedge clk);
    check("gate_ready_up", CL_W'(ready), CL_W'(1));

    // reset during RD_WAIT
    @(negedge clk);
    dma_rd_empty = 1'b1;
    ch_op   = 4'b0001;
    ch_addr = 128'h5000_0010;
    ch_req  = 2'b01;
    repeat (3) @(negedge clk);
    check("mid_busy",    CL_W'(ready), CL_W'(0));
    check("mid_rd_addr", CL_W'(dma_rd_addr), CL_W'(64'h5000_0000));
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready",   CL_W'(ready), CL_W'(1));
    check("arst_rd_addr", CL_W'(dma_rd_addr), CL_W'(0));
    check("arst_pulses",  CL_W'({dma_rd_go, dma_rd_en, dma_wr_go, dma_wr_en, ch_done, ch_err}), CL_W'(0));
    check("arst_wr_data", dma_wr_data, CL_W'(0));
    ch_req = '0;
    dma_rd_empty = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1, 2'b01, 64'h4000_0008, 32'h0, lat, dn, er, rd);
    check("post_rst_lat",  CL_W'(lat), CL_W'(4));
    check("post_rst_done", CL_W'(dn), CL_W'(2'b10));
    check("post_rst_data", CL_W'(rd), CL_W'(2));

`ifdef MEM_XFER_LINE_CACHE_EN
    b_rd = n_rd_go;
    xfer(0, 2'b01, 64'h1000_0040, 32'h0, lat, dn, er, rd);
    check("c_miss_lat",  CL_W'(lat), CL_W'(4));
    check("c_miss_data", CL_W'(rd), CL_W'(0));
    xfer(0, 2'b01, 64'h1000_0048, 32'h0, lat, dn, er, rd);
    check("c_hit_lat",   CL_W'(lat), CL_W'(1));
    check("c_hit_data",  CL_W'(rd), CL_W'(2));
    check("c_rd_go_cnt", CL_W'(n_rd_go - b_rd), CL_W'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
